bp_fe_bp_update_queue: RTL and testbench
========================================

Name: bp_fe_bp_update_queue

Overview:
- In-order tracker of in-flight branch predictions, sitting directly upstream of the gshare predictor's update port.
- Records each issued prediction: raw BHT index and predicted direction.
- When the backend resolves the oldest branch, compares the actual outcome with the recorded prediction.
- Drives a registered single-cycle update (valid, index, correct) into the predictor, and squashes wrong-path entries on mispredict or external flush.

Parameters:
- bht_idx_width_p, 8: width of the raw BHT index, matching the predictor's index width.
- els_p, 8: queue depth; must be a power of 2 and ≥2.
- flush_on_mispredict_p, 1: when 1, a mispredicted resolution discards all younger entries.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- pred_v_i  in  1  new prediction issued this cycle.
- pred_idx_i  in  bht_idx_width_p  raw (unhashed) index used for the prediction.
- pred_taken_i  in  1  predicted direction (1 = taken).
- pred_ready_o  out  1  queue can accept a prediction; equals ~full.
- res_v_i  in  1  oldest in-flight branch resolved this cycle.
- res_taken_i  in  1  actual direction.
- flush_i  in  1  squash all in-flight entries (frontend redirect).
- w_v_o  out  1  update valid to predictor.
- idx_w_o  out  bht_idx_width_p  raw index to update.
- correct_o  out  1  1 if the recorded prediction matched the outcome.
- mispredict_o  out  1  equals w_v_o & ~correct_o.
- count_o  out  $clog2(els_p)+1  current occupancy.
- empty_o  out  1  count_o == 0.
- err_o  out  1  sticky: resolution received while empty.

Behaviour:
- Clock and reset: one clock (clk_i); reset_i is synchronous and active-high.
- Reset values: count_o=0, empty_o=1, pred_ready_o=1, w_v_o=0, idx_w_o=0, correct_o=0, mispredict_o=0, err_o=0. Reset mid-operation discards all entries and any pending update.
- Storage: circular buffer of els_p entries {idx, taken}. Read/write pointers carry an extra wrap bit; full = pointers equal except wrap bit; empty = pointers fully equal.
- Enqueue: pred_v_i & pred_ready_o writes at the write pointer; entry is visible from the next cycle. pred_v_i while full is dropped silently; no state change.
- Dequeue: res_v_i & ~empty pops the head. Next cycle: w_v_o=1, idx_w_o=head.idx, correct_o=(head.taken==res_taken_i). Outputs are registered, latency exactly 1 cycle, w_v_o high for one cycle per resolution.
- res_v_i while empty: ignored, no update issued, err_o set until reset.
- No bypass: a same-cycle enqueue into an empty queue cannot be resolved that cycle. Full queue with same-cycle dequeue still refuses enqueue, since pred_ready_o is derived from the registered state.
- Simultaneous enqueue and dequeue on a non-full, non-empty queue: both occur; count unchanged.
- Mispredict squash (flush_on_mispredict_p=1): on a popping resolution with a mismatch, all remaining entries and any same-cycle enqueue are discarded. Next cycle count_o=0; the pop's own update is still issued.
- flush_i: any same-cycle valid resolution is processed first (update still issued next cycle), then all entries are discarded. Same-cycle enqueue is dropped. Next cycle count_o=0.
- Pointer wrap: pointers increment modulo 2*els_p; no ordering loss across wrap.
- count_o updates one cycle after the enqueue/dequeue/flush edge.

Optional Feature:
- Macro: BP_FE_BP_UPDATE_QUEUE_STATS_EN.
- When defined: adds outputs stat_resolved_o [31:0] and stat_mispredict_o [31:0].
  - stat_resolved_o increments on each issued update; stat_mispredict_o increments when mispredict_o=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
  - Update timing: on the same edge that raises w_v_o.
- When undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then enqueue {idx=8'h12,taken=1}, resolve res_taken_i=1 two cycles later → one cycle after res_v_i: w_v_o=1, idx_w_o=8'h12, correct_o=1, mispredict_o=0; count_o returns to 0.
- Enqueue 8 entries with idx 0..7 (els_p=8) → pred_ready_o=0. A 9th pred_v_i is dropped. Resolve all 8 in order → idx_w_o sequence 0..7, empty_o=1.
- Enqueue {3,T},{4,T},{5,N}; resolve head with res_taken_i=0 → correct_o=0, mispredict_o=1, idx_w_o=3; count_o=0 next cycle (flush_on_mispredict_p=1). With parameter 0, count_o=2.
- Enqueue 3 entries; assert flush_i together with res_v_i and pred_v_i → one update issued for the head; the new prediction is dropped; count_o=0.
- Reset, then res_v_i=1 while empty → no w_v_o; err_o=1 and stays 1 until reset.
- Run 20 enqueue/dequeue pairs through depth 8 (pointer wrap twice), including same-cycle push+pop → updates issued in FIFO order. With BP_FE_BP_UPDATE_QUEUE_STATS_EN: stat_resolved_o=20 and stat_mispredict_o matches the injected mismatch count.

Source files
------------

// File: rtl/bp_fe_bp_update_queue.sv
// bp_fe_bp_update_queue
// In-order tracker of in-flight branch predictions feeding the gshare
// predictor's update port. Each issued prediction records {raw index,
// predicted direction}. When the backend resolves the oldest branch, the
// recorded prediction is compared against the actual outcome. The result is
// then driven as a registered single-cycle update (valid, index, correct).
// Wrong-path entries are squashed on a mispredict (optional, by parameter)
// or on an external flush.
//
// Optional build macro: BP_FE_BP_UPDATE_QUEUE_STATS_EN adds saturating
// resolved/mispredict counters (stat_resolved_o, stat_mispredict_o).
//
// Handshake: a prediction is accepted on a cycle where pred_v_i and
// pred_ready_o are both high. pred_ready_o depends only on registered
// occupancy, never on same-cycle inputs. A prediction offered while not
// ready is dropped without any state change. res_v_i has no ready; it pops
// the head when the queue is non-empty and otherwise only raises err_o.
module bp_fe_bp_update_queue #(
  parameter int bht_idx_width_p       = 8,
  parameter int els_p                 = 8,
  parameter int flush_on_mispredict_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic                       mispredict_o,
  output logic [$clog2(els_p):0]     count_o,
  output logic                       empty_o,
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
  output logic [31:0]                stat_resolved_o,
  output logic [31:0]                stat_mispredict_o,
`endif
  output logic                       err_o
);

  localparam int lg_lp = $clog2(els_p);
  localparam logic [lg_lp:0] ptr_one_lp = {{lg_lp{1'b0}}, 1'b1};

  // Entry storage; no reset needed because the pointers define validity.
  logic [bht_idx_width_p-1:0] idx_mem_q   [els_p];
  logic                       taken_mem_q [els_p];

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [lg_lp:0] wptr_q, wptr_d;
  logic [lg_lp:0] rptr_q, rptr_d;

  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;
  logic                       err_q, err_d;

  logic full, empty;
  logic enq, deq, match, squash;
  logic [bht_idx_width_p-1:0] head_idx;
  logic                       head_taken;

  assign full  = (wptr_q[lg_lp-1:0] == rptr_q[lg_lp-1:0]) &&
                 (wptr_q[lg_lp] != rptr_q[lg_lp]);
  assign empty = (wptr_q == rptr_q);

  assign head_idx   = idx_mem_q[rptr_q[lg_lp-1:0]];
  assign head_taken = taken_mem_q[rptr_q[lg_lp-1:0]];

  // Decode this cycle's pop, enqueue and squash decisions.
  always_comb begin
    deq    = res_v_i & ~empty;
    match  = (head_taken == res_taken_i);
    squash = flush_i | ((flush_on_mispredict_p != 0) & deq & ~match);
    enq    = pred_v_i & ~full & ~squash;
  end

  // Next-state for pointers, registered update outputs and the sticky error.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    w_v_d     = deq;
    idx_w_d   = idx_w_q;
    correct_d = deq & match;
    err_d     = err_q | (res_v_i & empty);
    if (enq) begin
      wptr_d = wptr_q + ptr_one_lp;
    end
    if (squash) begin
      // Everything still in flight (after any pop) is wrong-path.
      rptr_d = wptr_q;
    end else if (deq) begin
      rptr_d = rptr_q + ptr_one_lp;
    end
    if (deq) begin
      idx_w_d = head_idx;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      w_v_q     <= 1'b0;
      idx_w_q   <= '0;
      correct_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      w_v_q     <= w_v_d;
      idx_w_q   <= idx_w_d;
      correct_q <= correct_d;
      err_q     <= err_d;
    end
  end

  // Entry write at the write pointer on an accepted prediction.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      idx_mem_q[wptr_q[lg_lp-1:0]]   <= pred_idx_i;
      taken_mem_q[wptr_q[lg_lp-1:0]] <= pred_taken_i;
    end
  end

`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
  logic [31:0] stat_res_q, stat_mis_q;

  // Saturating counters that advance on the edge that raises w_v_o.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (deq && (stat_res_q != 32'hFFFF_FFFF)) begin
        stat_res_q <= stat_res_q + 32'd1;
      end
      if (deq && !match && (stat_mis_q != 32'hFFFF_FFFF)) begin
        stat_mis_q <= stat_mis_q + 32'd1;
      end
    end
  end

  assign stat_resolved_o   = stat_res_q;
  assign stat_mispredict_o = stat_mis_q;
`endif

  assign pred_ready_o = ~full;
  assign w_v_o        = w_v_q;
  assign idx_w_o      = idx_w_q;
  assign correct_o    = correct_q;
  assign mispredict_o = w_v_q & ~correct_q;
  assign count_o      = wptr_q - rptr_q;
  assign empty_o      = empty;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Testbench for bp_fe_bp_update_queue (default parameters: idx 8, depth 8,
// flush on mispredict). Directed vectors; expected updates go into a
// scoreboard queue and are checked by an independent monitor.
module tb_bp_fe_bp_update_queue;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         pred_v_i;
  logic [W-1:0] pred_idx_i;
  logic         pred_taken_i;
  logic         pred_ready_o;
  logic         res_v_i;
  logic         res_taken_i;
  logic         flush_i;
  logic         w_v_o;
  logic [W-1:0] idx_w_o;
  logic         correct_o;
  logic         mispredict_o;
  logic [3:0]   count_o;
  logic         empty_o;
  logic         err_o;
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
  logic [31:0]  stat_resolved_o;
  logic [31:0]  stat_mispredict_o;
`endif

  int checks = 0;
  int errors = 0;

  // Expected update: {idx, correct}
  logic [W:0] exp_q[$];

  bp_fe_bp_update_queue dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .pred_v_i          (pred_v_i),
    .pred_idx_i        (pred_idx_i),
    .pred_taken_i      (pred_taken_i),
    .pred_ready_o      (pred_ready_o),
    .res_v_i           (res_v_i),
    .res_taken_i       (res_taken_i),
    .flush_i           (flush_i),
    .w_v_o             (w_v_o),
    .idx_w_o           (idx_w_o),
    .correct_o         (correct_o),
    .mispredict_o      (mispredict_o),
    .count_o           (count_o),
    .empty_o           (empty_o),
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
    .stat_resolved_o   (stat_resolved_o),
    .stat_mispredict_o (stat_mispredict_o),
`endif
    .err_o             (err_o)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    pred_v_i = 1'b0; res_v_i = 1'b0; flush_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Driver tasks
  task automatic push(input logic [W-1:0] idx, input logic taken);
    pred_v_i = 1'b1; pred_idx_i = idx; pred_taken_i = taken;
    tick();
    pred_v_i = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [W-1:0] exp_idx, input logic exp_correct);
    res_v_i = 1'b1; res_taken_i = taken;
    exp_q.push_back({exp_idx, exp_correct});
    tick();
    res_v_i = 1'b0;
  endtask

  // Monitor / scoreboard: every update presented by the DUT must match the
  // oldest expected entry.
  always @(negedge clk_i) begin
    if (!reset_i && w_v_o) begin
      logic [W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: got idx %0h correct %0b expected none", idx_w_o, correct_o);
      end else begin
        e = exp_q.pop_front();
        if (idx_w_o !== e[W:1] || correct_o !== e[0] || mispredict_o !== ~e[0]) begin
          errors++;
          $display("FAIL update: got idx %0h correct %0b mispredict %0b expected idx %0h correct %0b mispredict %0b",
                   idx_w_o, correct_o, mispredict_o, e[W:1], e[0], ~e[0]);
        end
      end
    end
  end

  initial begin
    pred_idx_i = '0; pred_taken_i = 1'b0; res_taken_i = 1'b0;
    do_reset();

    // Reset state
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_ready", pred_ready_o, 1);
    check("rst_w_v", w_v_o, 0);
    check("rst_idx", idx_w_o, 0);
    check("rst_correct", correct_o, 0);
    check("rst_mispredict", mispredict_o, 0);
    check("rst_err", err_o, 0);

    // Single prediction, correct resolution two cycles later
    push(8'h12, 1'b1);
    check("t1_count1", count_o, 1);
    tick();
    resolve(1'b1, 8'h12, 1'b1);
    check("t1_count0", count_o, 0);
    tick();
    check("t1_w_v_low", w_v_o, 0);

    // Fill to depth, drop a 9th, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) push(W'(i), i[0]);
    check("t2_ready", pred_ready_o, 0);
    check("t2_count8", count_o, 8);
    push(8'hAA, 1'b1);
    check("t2_drop_count", count_o, 8);
    for (int i = 0; i < 8; i++) resolve(i[0], W'(i), 1'b1);
    check("t2_empty", empty_o, 1);
    tick();

    // Mispredict squashes younger entries
    do_reset();
    push(8'h03, 1'b1);
    push(8'h04, 1'b1);
    push(8'h05, 1'b0);
    resolve(1'b0, 8'h03, 1'b0);
    check("t3_count0", count_o, 0);
    push(8'h09, 1'b1);
    resolve(1'b1, 8'h09, 1'b1);
    tick();

    // Flush with same-cycle resolution and prediction
    push(8'h20, 1'b0);
    push(8'h21, 1'b1);
    push(8'h22, 1'b0);
    flush_i = 1'b1;
    pred_v_i = 1'b1; pred_idx_i = 8'h30; pred_taken_i = 1'b1;
    resolve(1'b0, 8'h20, 1'b1);
    flush_i = 1'b0; pred_v_i = 1'b0;
    check("t4_count0", count_o, 0);
    check("t4_empty", empty_o, 1);
    push(8'h40, 1'b1);
    resolve(1'b1, 8'h40, 1'b1);
    tick();
    check("t4_drained", exp_q.size(), 0);

    // Resolution while empty sets sticky error, no update
    do_reset();
    res_v_i = 1'b1; res_taken_i = 1'b1;
    tick();
    res_v_i = 1'b0;
    check("t5_err", err_o, 1);
    tick(); tick();
    check("t5_err_sticky", err_o, 1);
    check("t5_no_update", w_v_o, 0);
    do_reset();
    check("t5_err_clr", err_o, 0);

    // 20 resolutions with pointer wrap, steady push+pop
    push(8'h50, 1'b0);
    for (int k = 1; k < 20; k++) begin
      pred_v_i = 1'b1; pred_idx_i = W'(8'h50 + k); pred_taken_i = k[0];
      resolve(k[0] ^ 1'b1, W'(8'h50 + k - 1), 1'b1);
      pred_v_i = 1'b0;
      if (k == 10) check("t6_count_steady", count_o, 1);
    end
    // Entry 19 predicted taken; resolve not-taken to inject one mispredict
    resolve(1'b0, 8'h63, 1'b0);
    tick();
    check("t6_count0", count_o, 0);
    check("t6_drained", exp_q.size(), 0);
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
    check("t6_stat_res", stat_resolved_o, 20);
    check("t6_stat_mis", stat_mispredict_o, 1);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
